// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry unit: FSM states, key map and
// row-decoding helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Indexed KEY_MAP[row][col]; the first nibble below is row 0, column 0.
    localparam logic [0:3][0:3][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous keypad rows; flops reset high
// so an idle keypad reads as all rows released.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_entry_unit.sv
// 4x4 keypad scanner with debounced press/release and a four-digit shift
// register holding the last keys entered.
module keypad_entry_unit
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clr_entry,
    output logic [3:0]  col,
    output logic [15:0] out,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] rs;

    state_t            state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        pat_q, pat_d;
    logic [1:0]        key_r_q, key_r_d;
    logic [15:0]       out_q, out_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (row),
        .q_o   (rs)
    );

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        pat_d      = pat_q;
        key_r_d    = key_r_q;
        out_d      = out_q;
        code_d     = code_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_SCAN: begin
                // A detected press freezes the column; the scan count is kept
                // so rotation resumes where it left off.
                if (rs != ROW_IDLE) begin
                    state_d   = ST_DEBOUNCE;
                    deb_cnt_d = '0;
                    pat_d     = rs;
                    key_r_d   = lowest_low(rs);
                end else if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    col_idx_d  = col_idx_q + 2'd1;
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rs != pat_q) begin
                    state_d   = ST_SCAN;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                    valid_d   = 1'b1;
                    code_d    = KEY_MAP[key_r_q][col_idx_q];
                    out_d     = {out_q[11:0], KEY_MAP[key_r_q][col_idx_q]};
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (rs == ROW_IDLE) begin
                    state_d   = ST_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            ST_RELEASE: begin
                if (rs != ROW_IDLE) begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_SCAN;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = ST_SCAN;
                deb_cnt_d = '0;
            end
        endcase

        if (clr_entry) out_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SCAN;
            col_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            pat_q      <= ROW_IDLE;
            key_r_q    <= 2'd0;
            out_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            pat_q      <= pat_d;
            key_r_q    <= key_r_d;
            out_q      <= out_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign out       = out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;

endmodule

// File: doc/keypad_entry_unit.md
KEYPAD_ENTRY_UNIT -- requirements
Module: keypad_entry_unit

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4096: clock cycles each column stays driven while scanning.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a press or a release.
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- clock  input  1  system clock, all logic on the rising edge
- reset  input  1  asynchronous, active-high reset
REQ-004 SHALL have the following further ports:
- row  input  4  keypad rows, active-low, asynchronous to clock
- clr_entry  input  1  synchronous clear of the entry value
- col  output  4  column drive, one-hot active-low
- out  output  16  entry value, last four digits entered
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse per accepted key

Function
REQ-005 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized row (rs), 2 cycles of latency.
REQ-006 SHALL implement the FSM states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-007 In SCAN, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles; the wrap from column 3 to column 0 is seamless.
REQ-008 In SCAN, when rs != 4'b1111, the block SHALL freeze col, capture the column index c and the lowest row index r with rs[r]=0, capture rs, and go to DEBOUNCE.
REQ-009 In DEBOUNCE, the counter SHALL increment each cycle while rs equals the captured pattern; any mismatch SHALL return the FSM to SCAN with the counter cleared and rotation resumed from the same column.
REQ-010 When the counter reaches DEBOUNCE_CYCLES-1, the block SHALL assert key_valid for exactly one cycle, load key_code, shift the entry value, and go to HELD.
REQ-011 Key map [r][c] SHALL be:
- row 0: 1 2 3 A
- row 1: 4 5 6 B
- row 2: 7 8 9 C
- row 3: E 0 F D
REQ-012 On accept, out SHALL become {out[11:0], key_code}; the oldest digit is discarded and there is no saturation.
REQ-013 In HELD, the block SHALL wait for rs == 4'b1111 and then go to RELEASE.
REQ-014 In RELEASE, the block SHALL require DEBOUNCE_CYCLES consecutive all-high cycles before returning to SCAN; any low row SHALL return the FSM to HELD. The key is accepted once per press, with no auto-repeat.
REQ-015 Extra keys pressed while in DEBOUNCE, HELD or RELEASE SHALL be ignored until the FSM is back in SCAN.
REQ-016 clr_entry SHALL set out to 0 on the next edge. If it coincides with an accept, clr_entry wins for out, while key_valid and key_code still update.
REQ-017 key_valid SHALL never be high in two consecutive cycles.

Reset
REQ-018 While reset is asserted, the block SHALL hold state=SCAN, col=4'b1110, out=0, key_code=0, key_valid=0, the counters at 0 and the synchronizer flops at 1.
REQ-019 A reset asserted mid-debounce or mid-hold SHALL abort with no key_valid pulse; after release, the block SHALL rescan from column 0.

Structure
REQ-020 A shared package keypad_pkg SHALL hold:
- the state enum
- the 4x4 key-map constant
- the all-high row constant
REQ-021 The synchronizer SHALL be the sub-module sync2 (width parameter); the FSM, the scan counter and the debounce counter live in keypad_entry_unit.
REQ-022 Counter widths SHALL derive from $clog2 of the parameters.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-023 Reset, then idle rows=1111 for 32 cycles -> col cycles 1110, 1101, 1011, 0111, each held 4 cycles; key_valid stays 0.
REQ-024 Press key "5" (row 1 low while col=1101) for 20 cycles, then release for 20 cycles -> exactly one key_valid pulse, key_code=5, out=0x0005.
REQ-025 Enter 1, 2, 3, A, 9 -> out=0x123A, then 0x23A9; clr_entry asserted in the same cycle as a further accept of "0" -> out=0x0000 and key_code=0.
REQ-026 Bounce: row low for 5 cycles, high for 1, low for 5 -> no key_valid; then held low for 12 cycles -> one pulse.
REQ-027 Rows 0 and 2 both low on col 0 -> key_code=1; reset asserted during HELD -> col=1110 and no pulse.
